// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the binary-to-7-segment feeder.
//   SEG_DIGIT    active-low segment codes for decimal digits 0..9 (bit 0 = a .. bit 6 = g)
//   SEG_BLANK    all segments off
//   SEG_DASH     only segment g lit
//   MAX_DISPLAY  largest value that fits in four decimal digits
//   state_t      conversion FSM states
//   dabble_adjust  add-3 correction applied to every BCD nibble before each shift
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam int unsigned MAX_DISPLAY = 9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_t;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
        logic [15:0] r;
        r = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// seg7_encoder: combinational BCD digit to active-low 7-segment code.
//   bcd  in  4  BCD digit; codes above 9 produce a blank
//   seg  out 7  segments g..a, active-low
module seg7_encoder (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9)
            seg = SEG_DIGIT[bcd];
    end

endmodule

// File: rtl/bin_to_seg_digits.sv
// bin_to_seg_digits: accepts a binary value over valid/ready, converts it to BCD
// with a one-bit-per-cycle double-dabble and registers four active-low digit bytes.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   in_valid  in   request to convert bin_in
//   in_ready  out  idle, a request will be accepted
//   bin_in    in   unsigned value to display
//   blank_en  in   leading-zero blanking enable (latched on accept)
//   dot_sel   in   decimal-point mask, bit n -> digit n (latched on accept)
//   done      out  one-cycle pulse when new digit bytes are visible
//   data_0..3 out  digit bytes: [7] dot, [6:0] segments g..a, all active-low
module bin_to_seg_digits #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             blank_en,
    input  logic [3:0]       dot_sel,
    output logic             done,
    output logic [7:0]       data_0,
    output logic [7:0]       data_1,
    output logic [7:0]       data_2,
    output logic [7:0]       data_3
);
    import seg7_pkg::*;

    localparam int CW = $clog2(BIN_W + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [BIN_W-1:0] bin_q;
    logic [15:0]      bcd_q;
    logic             blank_q;
    logic             ovf_q;
    logic [3:0]       dot_q;

    logic [3:0][6:0]  enc;
    logic [3:0][6:0]  seg;
    logic [3:0]       blank_dig;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CONV;
            CONV:    if (cnt == CW'(1)) state_nxt = UPD;
            UPD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    // ---------------- digit encoding ----------------
    for (genvar g = 0; g < 4; g++) begin : g_enc
        seg7_encoder u_enc (
            .bcd (bcd_q[4*g +: 4]),
            .seg (enc[g])
        );
    end

    // Blanking walks down from the thousands digit and stops at the first
    // nonzero digit; the ones digit is always shown. Overflow overrides both.
    always_comb begin
        blank_dig    = '0;
        blank_dig[3] = blank_q && (bcd_q[15:12] == 4'd0);
        blank_dig[2] = blank_dig[3] && (bcd_q[11:8] == 4'd0);
        blank_dig[1] = blank_dig[2] && (bcd_q[7:4] == 4'd0);
        for (int unsigned i = 0; i < 4; i++) begin
            if (ovf_q)
                seg[i] = SEG_DASH;
            else if (blank_dig[i])
                seg[i] = SEG_BLANK;
            else
                seg[i] = enc[i];
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            blank_q <= 1'b0;
            ovf_q   <= 1'b0;
            dot_q   <= '0;
            done    <= 1'b0;
            data_0  <= '1;
            data_1  <= '1;
            data_2  <= '1;
            data_3  <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_q   <= bin_in;
                        bcd_q   <= '0;
                        blank_q <= blank_en;
                        dot_q   <= dot_sel;
                        // Overflow is judged on the raw input since bin_q is consumed by the shift.
                        ovf_q   <= (bin_in > BIN_W'(MAX_DISPLAY));
                        cnt     <= CW'(BIN_W);
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {dabble_adjust(bcd_q), bin_q} << 1;
                    cnt            <= cnt - CW'(1);
                end
                UPD: begin
                    data_0 <= {~dot_q[0], seg[0]};
                    data_1 <= {~dot_q[1], seg[1]};
                    data_2 <= {~dot_q[2], seg[2]};
                    data_3 <= {~dot_q[3], seg[3]};
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_seg_digits.sv
module tb_bin_to_seg_digits;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] bin_in;
    logic             blank_en;
    logic [3:0]       dot_sel;
    logic             done;
    logic [7:0]       data_0, data_1, data_2, data_3;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] SEG_TB [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef struct {
        int unsigned val;
        bit          blank;
        logic [3:0]  dots;
        logic [31:0] exp;   // {data_3, data_2, data_1, data_0}
        bit          pulse;
    } vec_t;

    vec_t vt [13];

    bin_to_seg_digits #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bin_in   (bin_in),
        .blank_en (blank_en),
        .dot_sel  (dot_sel),
        .done     (done),
        .data_0   (data_0),
        .data_1   (data_1),
        .data_2   (data_2),
        .data_3   (data_3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] outs();
        return {data_3, data_2, data_1, data_0};
    endfunction

    // Reference: decimal digits by division, blanking and overflow from the display rules.
    function automatic logic [31:0] model(input int unsigned v, input bit blank, input logic [3:0] dots);
        logic [7:0]  b [4];
        logic [7:0]  s;
        int unsigned d;
        int unsigned pw;
        bit          lead;
        lead = blank;
        for (int i = 3; i >= 0; i--) begin
            pw = 1;
            for (int k = 0; k < i; k++) pw = pw * 10;
            d = (v / pw) % 10;
            if (v > 9999)
                s = 8'hBF;
            else if (lead && i > 0 && d == 0)
                s = 8'hFF;
            else begin
                s    = SEG_TB[d];
                lead = 1'b0;
            end
            b[i] = {~dots[i], s[6:0]};
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One conversion: waits for in_ready, accepts, checks busy/hold behaviour and
    // latency, and returns the bytes visible on the cycle done is high.
    task automatic run_conv(input string tag, input int unsigned val, input bit blank,
                            input logic [3:0] dots, input bit pulse, output logic [31:0] got);
        int unsigned w;
        bit          busy_ok, hold_ok;
        logic [31:0] prev;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_ready_wait"}, {31'd0, in_ready}, 32'd1);
        prev     = outs();
        bin_in   = BIN_W'(val);
        blank_en = blank;
        dot_sel  = dots;
        in_valid = 1'b1;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                // change inputs right after accept to confirm they were latched
                in_valid = 1'b0;
                bin_in   = BIN_W'($urandom);
                blank_en = ~blank;
                dot_sel  = ~dots;
            end
            if (in_ready !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
            if (outs() !== prev) hold_ok = 1'b0;
            if (pulse && k == 4) begin
                in_valid = 1'b1;
                bin_in   = BIN_W'(42);
            end
            if (pulse && k == 5) in_valid = 1'b0;
        end
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {30'd0, done, in_ready}, 32'd3);
        got = outs();
    endtask

    initial begin
        logic [31:0] got;
        bit          no_done;
        int unsigned v;

        vt[0]  = '{1234,  1'b0, 4'b0000, 32'hF9A4B099, 1'b0};
        vt[1]  = '{7,     1'b1, 4'b0100, 32'hFF7FFFF8, 1'b0};
        vt[2]  = '{0,     1'b1, 4'b0000, 32'hFFFFFFC0, 1'b0};
        vt[3]  = '{0,     1'b0, 4'b0000, 32'hC0C0C0C0, 1'b0};
        vt[4]  = '{9999,  1'b0, 4'b0000, 32'h90909090, 1'b0};
        vt[5]  = '{10000, 1'b0, 4'b0000, 32'hBFBFBFBF, 1'b0};
        vt[6]  = '{10000, 1'b1, 4'b0001, 32'hBFBFBF3F, 1'b0};
        vt[7]  = '{5678,  1'b0, 4'b0000, 32'h9282F880, 1'b1};
        vt[8]  = '{16383, 1'b1, 4'b0000, 32'hBFBFBFBF, 1'b0};
        vt[9]  = '{100,   1'b1, 4'b1111, 32'h7F794040, 1'b0};
        vt[10] = '{10,    1'b1, 4'b0000, 32'hFFFFF9C0, 1'b0};
        vt[11] = '{1111,  1'b0, 4'b0000, 32'hF9F9F9F9, 1'b0};
        vt[12] = '{2222,  1'b0, 4'b0000, 32'hA4A4A4A4, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        blank_en = 1'b0;
        dot_sel  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 32'hFFFFFFFF);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_ready", {31'd0, in_ready}, 32'd1);

        // Table vectors; 1111 then 2222 run back-to-back on the first ready cycle.
        for (int i = 0; i < 13; i++) begin
            run_conv($sformatf("vec%0d", i), vt[i].val, vt[i].blank, vt[i].dots, vt[i].pulse, got);
            check($sformatf("vec%0d_data", i), got, vt[i].exp);
        end

        // Reset in the middle of a conversion.
        bin_in   = BIN_W'(4321);
        blank_en = 1'b0;
        dot_sel  = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_outs", outs(), 32'hFFFFFFFF);
        check("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        no_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done !== 1'b0) no_done = 1'b0;
            @(posedge clk); #1;
        end
        check("abort_no_done", {31'd0, no_done}, 32'd1);
        check("abort_outs_hold", outs(), 32'hFFFFFFFF);

        // Randomised values against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] d;
            bit         b;
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 16383);
            endcase
            b = 1'($urandom);
            d = 4'($urandom);
            run_conv($sformatf("rnd%0d", i), v, b, d, 1'b0, got);
            check($sformatf("rnd%0d_v%0d", i, v), got, model(v, b, d));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin_to_seg_digits.md
Name: bin_to_seg_digits

Overview:
- Upstream feeder for the 4-digit multiplexed 7-segment display controller.
- Accepts a binary value through a valid/ready handshake and converts it to BCD with an iterative double-dabble (one bit per cycle).
- Encodes each BCD digit to active-low segment bytes and holds the four digit bytes registered and stable until the next conversion completes.
- Supports optional leading-zero blanking, a per-digit decimal-point mask, and an overflow indication ("----").

Parameters:
- BIN_W, 14, width of the binary input; legal range 14..16; conversion takes BIN_W iterations.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  request to convert bin_in
- in_ready  out  1  block idle, can accept a request
- bin_in  in  BIN_W  unsigned value to display
- blank_en  in  1  enable leading-zero blanking; latched on accept
- dot_sel  in  4  active-high decimal-point mask, bit n maps to digit n; latched on accept
- done  out  1  one-cycle pulse: new digit bytes valid
- data_0  out  8  ones digit: [7] dot (active-low), [6:0] segments g..a (active-low)
- data_1  out  8  tens digit, same format
- data_2  out  8  hundreds digit, same format
- data_3  out  8  thousands digit, same format

Behaviour:
- Segment bit map (active-low): [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g.
- Digit codes [6:0], zero = segment on: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 (hex, bit 7 shown as 1).
- Special codes: blank=FF, dash=BF.
- Reset (rst=1 at posedge):
  - State goes to IDLE; data_0..data_3 = 8'hFF; done=0; iteration counter cleared.
  - in_ready=1 from the first cycle after reset deasserts.
  - A reset mid-conversion aborts it: no done pulse follows, and the outputs are forced to FF.
- FSM IDLE / CONV / UPD:
  - IDLE:
    - in_ready=1.
    - On a posedge with in_valid=1 (accept edge E0), latch bin_in, blank_en and dot_sel; clear the BCD register; load the counter with BIN_W; go to CONV.
  - CONV:
    - in_ready=0; in_valid is ignored.
    - Each edge: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1 and decrement the counter.
    - After BIN_W iterations (edge E_BIN_W), go to UPD.
  - UPD:
    - On edge E_(BIN_W+1), register the four output bytes and return to IDLE.
    - done=1 and in_ready=1 during the cycle following that edge only.
- Latency: accept edge to output update is BIN_W+1 edges (15 at default); the next accept is possible at the following edge.
- Outputs change only on the UPD edge or on reset; they never show intermediate values.
- Overflow: latched value >9999 gives all four segment fields = dash. Dots still apply; blanking is ignored.
- Blanking:
  - When blank_en=1, digits 3, 2 and 1 are blanked from the most significant digit downward while they are zero.
  - Blanking stops at the first nonzero digit.
  - Digit 0 is never blanked.
- Dot: data_n[7] = ~dot_sel[n], applied after blanking and overflow handling.
  - A blanked digit with its dot set gives 8'h7F.
- BCD register is 16 bits. For inputs >9999 its contents are don't-care, but the conversion still runs full length, so latency is constant.

Decomposition:
- Package seg7_pkg holds:
  - segment constant array SEG_DIGIT[0:9];
  - SEG_BLANK (7'h7F) and SEG_DASH (7'h3F);
  - MAX_DISPLAY = 9999;
  - FSM state enum (IDLE, CONV, UPD).
- Sub-module seg7_encoder: combinational, 4-bit BCD in, 7-bit active-low segments out (codes >9 produce blank).
  - Instantiated four times.

Test Plan:
- Accept 1234, blank_en=0, dot_sel=0 -> exactly 15 cycles later: data_3..0 = F9,A4,B0,99; done high 1 cycle; in_ready low during cycles 1-14 after accept.
- Accept 7, blank_en=1, dot_sel=4'b0100 -> data_3=FF, data_2=7F, data_1=FF, data_0=F8.
- Accept 0 with blank_en=1 -> FF,FF,FF,C0.
- Accept 0 with blank_en=0 -> C0 x4.
- Accept 9999 -> 90 x4.
- Accept 10000 -> BF x4.
- Accept 10000 with dot_sel=4'b0001 -> data_0=3F.
- Accept 5678; during CONV pulse in_valid with 42 -> 42 ignored, output 92,82,F8,80 (data_3..0).
- Then assert rst at iteration 6 of a new conversion -> all outputs FF next cycle, no done pulse, in_ready=1 after rst drops.
- Back-to-back: accept 1111, then 2222 on the first in_ready cycle -> outputs hold F9 x4 until the second UPD edge, then A4 x4; nothing intermediate is ever visible.
